traffic_light_monitor: RTL and testbench

Passive checker that sits on the red/yellow/green lamp outputs of the traffic light controller and verifies the lamp stream. It decodes the current phase and checks lamp legality, RED→GREEN→YELLOW→RED ordering and per-phase dwell time. It reports one-cycle error pulses, a sticky error flag and a count of completed light cycles. It is the consuming end of the lamp interface and is used both as an in-system health monitor and as a bench checker.

---
 rtl/traffic_light_monitor.sv | 161 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker on the red/yellow/green lamp stream: decodes the phase and flags
// illegal lamp codes, out-of-order transitions and wrong dwell times.
module traffic_light_monitor #(
  parameter int DWELL = 10,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          red,
  input  logic          yellow,
  input  logic          green,
  output logic [1:0]    phase,
  output logic          locked,
  output logic          err_lamp,
  output logic          err_order,
  output logic          err_dwell,
  output logic          err_sticky,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [1:0] {UNSYNC, SEEN, TRACK} st_e;

  localparam logic [1:0]    PH_RED    = 2'b00;
  localparam logic [1:0]    PH_GREEN  = 2'b01;
  localparam logic [1:0]    PH_YELLOW = 2'b10;
  localparam logic [1:0]    PH_NONE   = 2'b11;
  localparam logic [CW-1:0] DWELL_C   = CW'(DWELL);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + ONE_C;
  endfunction

  function automatic logic next_ok(input logic [1:0] from_ph, input logic [1:0] to_ph);
    case (from_ph)
      PH_RED:    return to_ph == PH_GREEN;
      PH_GREEN:  return to_ph == PH_YELLOW;
      PH_YELLOW: return to_ph == PH_RED;
      default:   return 1'b0;
    endcase
  endfunction

  st_e           st_q, st_d;
  logic [1:0]    cur_q, cur_d;
  logic [CW-1:0] run_q, run_d;
  logic          over_q, over_d;
  logic [1:0]    phase_q, phase_d;
  logic          locked_q, locked_d;
  logic          err_lamp_q, err_lamp_d;
  logic          err_order_q, err_order_d;
  logic          err_dwell_q, err_dwell_d;
  logic          err_sticky_q, err_sticky_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;

  logic          samp_legal;
  logic [1:0]    samp;

  always_comb begin
    samp_legal = 1'b1;
    samp       = PH_NONE;
    case ({red, green, yellow})
      3'b100:  samp = PH_RED;
      3'b010:  samp = PH_GREEN;
      3'b001:  samp = PH_YELLOW;
      default: samp_legal = 1'b0;
    endcase
  end

  always_comb begin
    st_d          = st_q;
    cur_d         = cur_q;
    run_d         = run_q;
    over_d        = over_q;
    cycle_count_d = cycle_count_q;
    err_lamp_d    = 1'b0;
    err_order_d   = 1'b0;
    err_dwell_d   = 1'b0;

    case (st_q)
      UNSYNC: begin
        // Illegal codes are ignored here so an all-dark lamp head after reset is not an error.
        if (samp_legal) begin
          cur_d  = samp;
          run_d  = ONE_C;
          over_d = 1'b0;
          st_d   = SEEN;
        end
      end
      SEEN, TRACK: begin
        if (!samp_legal) begin
          err_lamp_d = 1'b1;
          st_d       = UNSYNC;
          run_d      = '0;
          over_d     = 1'b0;
        end else if (samp == cur_q) begin
          run_d = sat_inc(run_q);
          if (st_q == TRACK && run_q == DWELL_C && !over_q) begin
            err_dwell_d = 1'b1;
            over_d      = 1'b1;
          end
        end else begin
          cur_d  = samp;
          run_d  = ONE_C;
          over_d = 1'b0;
          if (st_q == SEEN) begin
            // The first observed phase is partial, so only ordering is judged.
            if (next_ok(cur_q, samp)) st_d = TRACK;
            else                      err_order_d = 1'b1;
          end else begin
            err_order_d = !next_ok(cur_q, samp);
            err_dwell_d = (run_q < DWELL_C) && !over_q;
            if (cur_q == PH_YELLOW && samp == PH_RED)
              cycle_count_d = sat_inc(cycle_count_q);
          end
        end
      end
      default: st_d = UNSYNC;
    endcase

    phase_d      = (st_d == UNSYNC) ? PH_NONE : cur_d;
    locked_d     = (st_d == TRACK);
    err_sticky_d = err_sticky_q | err_lamp_d | err_order_d | err_dwell_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= UNSYNC;
      cur_q         <= PH_RED;
      run_q         <= '0;
      over_q        <= 1'b0;
      phase_q       <= PH_NONE;
      locked_q      <= 1'b0;
      err_lamp_q    <= 1'b0;
      err_order_q   <= 1'b0;
      err_dwell_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      st_q          <= st_d;
      cur_q         <= cur_d;
      run_q         <= run_d;
      over_q        <= over_d;
      phase_q       <= phase_d;
      locked_q      <= locked_d;
      err_lamp_q    <= err_lamp_d;
      err_order_q   <= err_order_d;
      err_dwell_q   <= err_dwell_d;
      err_sticky_q  <= err_sticky_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign phase       = phase_q;
  assign locked      = locked_q;
  assign err_lamp    = err_lamp_q;
  assign err_order   = err_order_q;
  assign err_dwell   = err_dwell_q;
  assign err_sticky  = err_sticky_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: segment table of lamp runs with expected state,
// plus hand-timed sequences for dwell pulses, count saturation and async reset.
module tb_traffic_light_monitor;

  localparam int CW = 8;
  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] G   = 3'b010;
  localparam logic [2:0] Y   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] RG  = 3'b110;

  logic          clk;
  logic          rst_n;
  logic          red, yellow, green;
  logic [1:0]    phase;
  logic          locked, err_lamp, err_order, err_dwell, err_sticky;
  logic [CW-1:0] cycle_count;

  traffic_light_monitor #(.DWELL(10), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .red(red), .yellow(yellow), .green(green),
    .phase(phase), .locked(locked), .err_lamp(err_lamp), .err_order(err_order),
    .err_dwell(err_dwell), .err_sticky(err_sticky), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] lamps;
    int         len;
    int         ph;
    int         lk;
    int         dl;
    int         dor;
    int         dd;
    int         cc;
  } seg_t;

  seg_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   c_lamp = 0, c_order = 0, c_dwell = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] l, input int n, input int ph, input int lk,
                     input int dl, input int dor, input int dd, input int cc);
    tbl.push_back('{l, n, ph, lk, dl, dor, dd, cc});
  endtask

  task automatic step(input logic [2:0] l);
    {red, green, yellow} = l;
    @(posedge clk);
    #1;
    c_lamp  += int'(err_lamp);
    c_order += int'(err_order);
    c_dwell += int'(err_dwell);
  endtask

  task automatic run(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) step(l);
  endtask

  initial begin
    int b_l, b_o, b_d, iter;

    // Nominal five cycles from reset, then short/long phase, lamp error, order error.
    add(OFF, 3, 3, 0, 0, 0, 0, 0);
    add(R, 10, 0, 0, 0, 0, 0, 0);
    add(G, 10, 1, 1, 0, 0, 0, 0);
    add(Y, 10, 2, 1, 0, 0, 0, 0);
    for (int k = 2; k <= 5; k++) begin
      add(R, 10, 0, 1, 0, 0, 0, k - 1);
      add(G, 10, 1, 1, 0, 0, 0, k - 1);
      add(Y, 10, 2, 1, 0, 0, 0, k - 1);
    end
    add(R,   1, 0, 1, 0, 0, 0, 5);
    add(R,   9, 0, 1, 0, 0, 0, 5);
    add(G,   9, 1, 1, 0, 0, 0, 5);
    add(Y,  10, 2, 1, 0, 0, 1, 5);
    add(R,  10, 0, 1, 0, 0, 0, 6);
    add(G,  10, 1, 1, 0, 0, 0, 6);
    add(Y,  11, 2, 1, 0, 0, 1, 6);
    add(R,  10, 0, 1, 0, 0, 0, 7);
    add(G,  10, 1, 1, 0, 0, 0, 7);
    add(RG,  1, 3, 0, 1, 0, 0, 7);
    add(G,   9, 1, 0, 0, 0, 0, 7);
    add(Y,  10, 2, 1, 0, 0, 0, 7);
    add(R,  10, 0, 1, 0, 0, 0, 8);
    add(Y,   1, 2, 1, 0, 1, 0, 8);
    add(Y,   9, 2, 1, 0, 0, 0, 8);
    add(R,  10, 0, 1, 0, 0, 0, 9);

    rst_n = 1'b0;
    {red, green, yellow} = OFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", phase, 3);
    chk("rst_locked", locked, 0);
    chk("rst_errs", {err_lamp, err_order, err_dwell}, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_count", cycle_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      b_l = c_lamp; b_o = c_order; b_d = c_dwell;
      run(tbl[i].lamps, tbl[i].len);
      chk($sformatf("seg%0d_phase", i), phase, tbl[i].ph);
      chk($sformatf("seg%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("seg%0d_err_lamp", i), c_lamp - b_l, tbl[i].dl);
      chk($sformatf("seg%0d_err_order", i), c_order - b_o, tbl[i].dor);
      chk($sformatf("seg%0d_err_dwell", i), c_dwell - b_d, tbl[i].dd);
      chk($sformatf("seg%0d_count", i), cycle_count, tbl[i].cc);
    end
    chk("tbl_sticky", err_sticky, 1);

    // Short GREEN: the pulse lands on the first YELLOW sample only.
    run(G, 9);
    step(Y);
    chk("short_dwell_pulse", err_dwell, 1);
    chk("short_no_order", err_order, 0);
    chk("short_phase", phase, 2);
    step(Y);
    chk("short_pulse_width", err_dwell, 0);
    run(Y, 8);
    chk("short_sticky", err_sticky, 1);

    // Long YELLOW: pulse on the 11th sample, nothing at YELLOW->RED.
    run(R, 10);
    chk("long_pre_count", cycle_count, 10);
    run(G, 10);
    run(Y, 9);
    step(Y);
    chk("long_y10_quiet", err_dwell, 0);
    step(Y);
    chk("long_y11_pulse", err_dwell, 1);
    step(R);
    chk("long_yr_quiet", err_dwell, 0);
    chk("long_count", cycle_count, 11);
    run(R, 9);

    // Drive the cycle count to saturation, then an order error and one more cycle.
    iter = 0;
    while (cycle_count != 8'd255 && iter < 300) begin
      run(G, 10);
      run(Y, 10);
      run(R, 10);
      iter++;
    end
    chk("sat_reached", cycle_count, 255);
    step(Y);
    chk("ord_pulse", err_order, 1);
    chk("ord_no_dwell", err_dwell, 0);
    chk("ord_locked", locked, 1);
    chk("ord_phase", phase, 2);
    run(Y, 9);
    step(R);
    chk("sat_no_wrap", cycle_count, 255);
    chk("sat_yr_no_order", err_order, 0);
    run(R, 9);

    // Async reset in the middle of an err_lamp pulse, lamps still active.
    step(G);
    step(RG);
    chk("mid_lamp_pulse", err_lamp, 1);
    {red, green, yellow} = G;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_phase", phase, 3);
    chk("async_locked", locked, 0);
    chk("async_err_lamp", err_lamp, 0);
    chk("async_sticky", err_sticky, 0);
    chk("async_count", cycle_count, 0);
    @(negedge clk);
    @(negedge clk);
    chk("hold_phase", phase, 3);
    rst_n = 1'b1;
    step(G);
    chk("resync_phase", phase, 1);
    chk("resync_unlocked", locked, 0);
    step(Y);
    chk("relock", locked, 1);
    chk("relock_phase", phase, 2);
    chk("relock_errs", {err_lamp, err_order, err_dwell}, 0);
    chk("relock_count", cycle_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
